// File: rtl/hls_ptr_reader_if.sv
// Avalon-MM burst read master plus Avalon-ST source bundle for hls_ptr_reader.
// The master modport is the reader side; the slave modport is the memory/sink side.
interface hls_ptr_reader_if #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
);
  localparam int BC_W = $clog2(MAX_BURST) + 1;

  logic [63:0]       avm_address_o;
  logic              avm_read_o;
  logic [BC_W-1:0]   avm_burstcount_o;
  logic              avm_waitrequest_i;
  logic [DATA_W-1:0] avm_readdata_i;
  logic              avm_readdatavalid_i;
  logic [DATA_W-1:0] src_data_o;
  logic              src_valid_o;
  logic              src_ready_i;

  modport master (
    output avm_address_o, avm_read_o, avm_burstcount_o, src_data_o, src_valid_o,
    input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i, src_ready_i
  );

  modport slave (
    input  avm_address_o, avm_read_o, avm_burstcount_o, src_data_o, src_valid_o,
    output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i, src_ready_i
  );
endinterface

// File: rtl/hls_ptr_reader.sv
// Fetches len_i words from ptr_i with credit-limited Avalon-MM bursts and replays
// them in order on an Avalon-ST source through a small read-data FIFO.
module hls_ptr_reader #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [63:0]      ptr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  hls_ptr_reader_if.master bus
);
  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [63:0] STEP = 64'(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              read_q, read_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push, pop, accept, credit_ok;

  function automatic logic [BC_W-1:0] burst_of(input logic [LEN_W-1:0] r);
    if (r >= LEN_W'(MAX_BURST)) return BC_W'(MAX_BURST);
    return BC_W'(r);
  endfunction

  assign push   = bus.avm_readdatavalid_i;
  assign pop    = (count_q != '0) && bus.src_ready_i;
  assign accept = read_q && !bus.avm_waitrequest_i;

  // head_q always holds the word that will sit at the FIFO head next cycle.
  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    outst_d = outst_q + (accept ? CNT_W'(bc_q) : '0) - CNT_W'(push);
    head_d  = head_q;
    if ((count_q - CNT_W'(pop)) != '0) head_d = mem_q[rd_ptr_q + PTR_W'(pop)];
    else if (push)                     head_d = bus.avm_readdata_i;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    bc_d      = bc_q;
    read_d    = read_q;
    done_d    = 1'b0;
    credit_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = {ptr_i[63:2], 2'b00};
          rem_d  = len_i;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            // FIFO and outstanding are zero here, so the first burst always fits.
            bc_d    = burst_of(len_i);
            read_d  = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          addr_d = addr_q + 64'(bc_q) * STEP;
          rem_d  = rem_q - LEN_W'(bc_q);
          bc_d   = burst_of(rem_d);
        end else if (!read_q) begin
          bc_d = burst_of(rem_q);
        end
        // Credit is judged on next-cycle occupancy, the moment the request becomes visible.
        credit_ok = (32'(outst_d) + 32'(count_d) + 32'(bc_d)) <= 32'(FIFO_DEPTH);
        if (accept && rem_d == '0) begin
          read_d  = 1'b0;
          state_d = DRAIN;
        end else if (accept || !read_q) begin
          read_d = credit_ok;
        end
      end
      DRAIN: begin
        if (outst_q == '0 && count_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      bc_q     <= '0;
      read_q   <= 1'b0;
      done_q   <= 1'b0;
      outst_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      bc_q     <= bc_d;
      read_q   <= read_d;
      done_q   <= done_d;
      outst_q  <= outst_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.avm_readdata_i;
  end

  assign bus.avm_address_o    = addr_q;
  assign bus.avm_read_o       = read_q;
  assign bus.avm_burstcount_o = bc_q;
  assign bus.src_data_o       = head_q;
  assign bus.src_valid_o      = (count_q != '0);
  assign busy_o               = (state_q != IDLE);
  assign done_o               = done_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    bus.avm_readdatavalid_i |-> (count_q != CNT_W'(FIFO_DEPTH)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    bus.avm_readdatavalid_i |-> (outst_q != '0));
endmodule

// File: tb/tb_hls_ptr_reader.sv
// Randomized scoreboard bench for hls_ptr_reader: a memory responder, a reference
// model of bursts/words per transfer, and a monitor that pops and compares.
module tb_hls_ptr_reader;
  localparam int DATA_W = 32, LEN_W = 16, FIFO_DEPTH = 16, MAX_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] ptr = '0;
  logic [LEN_W-1:0] len = '0;
  logic start = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  hls_ptr_reader_if #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) bus ();

  hls_ptr_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ptr_i(ptr), .len_i(len), .start_i(start),
    .busy_o(busy), .done_o(done), .bus(bus)
  );

  int tests = 0, fails = 0;
  logic [31:0] exp_words[$];
  logic [63:0] exp_addr[$];
  int          exp_bc[$];
  logic [31:0] pend[$];
  int wait_mode = 0, stall_left = 0, ready_mode = 0;
  bit rdv_rand = 1'b0;
  int n_accepts = 0, n_stalls = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h expected nothing", name, act);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  // Reference: word-aligned base, bursts of min(MAX_BURST, remaining), words in address order.
  task automatic model_xfer(input logic [63:0] p, input int l);
    logic [63:0] a;
    int r, b;
    a = {p[63:2], 2'b00};
    r = l;
    for (int i = 0; i < l; i++) exp_words.push_back(word_at(a + 64'(4 * i)));
    while (r > 0) begin
      b = (r < MAX_BURST) ? r : MAX_BURST;
      exp_addr.push_back(a);
      exp_bc.push_back(b);
      a = a + 64'(4 * b);
      r = r - b;
    end
  endtask

  // Memory slave and sink: record accepted bursts, drive inputs just after each rising edge.
  initial begin
    bus.avm_waitrequest_i   = 1'b0;
    bus.avm_readdatavalid_i = 1'b0;
    bus.avm_readdata_i      = '0;
    bus.src_ready_i         = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) pend.delete();
      else if (bus.avm_read_o && !bus.avm_waitrequest_i)
        for (int b = 0; b < int'(bus.avm_burstcount_o); b++)
          pend.push_back(word_at(bus.avm_address_o + 64'(4 * b)));
      @(posedge clk);
      #1;
      if (stall_left > 0 && bus.avm_read_o) begin
        bus.avm_waitrequest_i = 1'b1;
        stall_left--;
      end else begin
        bus.avm_waitrequest_i = (wait_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      if (pend.size() > 0 && (!rdv_rand || $urandom_range(0, 1) == 1)) begin
        bus.avm_readdatavalid_i = 1'b1;
        bus.avm_readdata_i      = pend.pop_front();
      end else begin
        bus.avm_readdatavalid_i = 1'b0;
        bus.avm_readdata_i      = $urandom;
      end
      case (ready_mode)
        0:       bus.src_ready_i = 1'b1;
        1:       bus.src_ready_i = 1'($urandom_range(0, 1));
        default: bus.src_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares every accepted burst and every popped word against the model queues.
  initial begin
    bit prev_stall, prev_hold;
    logic [63:0] prev_addr;
    logic [31:0] prev_data;
    int prev_bc;
    prev_stall = 0; prev_hold = 0; prev_addr = '0; prev_data = '0; prev_bc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_hold  = 0;
      end else begin
        if (prev_stall) begin
          check("hold_read", 64'(bus.avm_read_o), 64'd1);
          check("hold_addr", bus.avm_address_o, prev_addr);
          check("hold_bc", 64'(bus.avm_burstcount_o), 64'(prev_bc));
        end
        prev_stall = bus.avm_read_o && bus.avm_waitrequest_i;
        if (prev_stall) begin
          prev_addr = bus.avm_address_o;
          prev_bc   = int'(bus.avm_burstcount_o);
          n_stalls++;
        end
        if (bus.avm_read_o && !bus.avm_waitrequest_i) begin
          n_accepts++;
          if (exp_addr.size() == 0) fail_unexpected("burst_unexpected", bus.avm_address_o);
          else begin
            check("burst_addr", bus.avm_address_o, exp_addr.pop_front());
            check("burst_len", 64'(bus.avm_burstcount_o), 64'(exp_bc.pop_front()));
          end
        end
        if (prev_hold) check("src_hold", 64'(bus.src_data_o), 64'(prev_data));
        prev_hold = bus.src_valid_o && !bus.src_ready_i;
        prev_data = bus.src_data_o;
        if (bus.src_valid_o && bus.src_ready_i) begin
          if (exp_words.size() == 0) fail_unexpected("src_unexpected", 64'(bus.src_data_o));
          else check("src_data", 64'(bus.src_data_o), 64'(exp_words.pop_front()));
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic start_xfer(input logic [63:0] p, input int l);
    model_xfer(p, l);
    done_cnt = 0;
    @(posedge clk); #1;
    ptr = p; len = LEN_W'(l); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ptr = {$urandom, $urandom};
    len = LEN_W'($urandom);
    @(negedge clk);
    if (l != 0) begin
      check("busy_after_start", 64'(busy), 64'd1);
      check("read_at_cycle1", 64'(bus.avm_read_o), 64'd1);
    end
  endtask

  task automatic finish_xfer(input string name, input logic [63:0] p, input int l, input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check({name, "_one_done"}, 64'(done_cnt), 64'd1);
    check({name, "_idle"}, 64'(busy), 64'd0);
    check({name, "_words_left"}, 64'(exp_words.size()), 64'd0);
    check({name, "_bursts_left"}, 64'(exp_addr.size()), 64'd0);
    $display("[TB] xfer %s ptr=0x%0h len=%0d cycles=%0d", name, p, l, c);
  endtask

  initial begin
    int a0, s0, c;
    logic [63:0] p;
    int l;
    repeat (3) @(negedge clk);
    check("rst_read", 64'(bus.avm_read_o), 64'd0);
    check("rst_valid", 64'(bus.src_valid_o), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain 20-word fetch: bursts 8, 8, 4.
    start_xfer(64'h1000, 20);
    finish_xfer("basic20", 64'h1000, 20, 500);

    // Zero length: done one cycle after start, no read, no busy.
    a0 = n_accepts;
    done_cnt = 0;
    @(posedge clk); #1;
    ptr = 64'h1000; len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("len0_done_cycle1", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_read", 64'(bus.avm_read_o), 64'd0);
    repeat (3) @(negedge clk);
    check("len0_one_done", 64'(done_cnt), 64'd1);
    check("len0_no_burst", 64'(n_accepts - a0), 64'd0);
    $display("[TB] xfer len0 ptr=0x1000 len=0");

    // Sink stalled: credit allows exactly two bursts of 8.
    ready_mode = 2;
    a0 = n_accepts;
    start_xfer(64'h2000, 40);
    repeat (40) @(negedge clk);
    check("credit_bursts", 64'(n_accepts - a0), 64'd2);
    check("credit_read_low", 64'(bus.avm_read_o), 64'd0);
    check("credit_words_held", 64'(exp_words.size()), 64'd40);
    ready_mode = 0;
    finish_xfer("credit40", 64'h2000, 40, 1000);

    // Waitrequest for 5 cycles on the first burst.
    a0 = n_accepts;
    s0 = n_stalls;
    stall_left = 5;
    start_xfer(64'h3000, 8);
    finish_xfer("stall8", 64'h3000, 8, 500);
    check("stall_accepts", 64'(n_accepts - a0), 64'd1);
    check("stall_cycles", 64'(n_stalls - s0), 64'd5);

    // Unaligned pointer is aligned down.
    start_xfer(64'h1003, 1);
    check("unaligned_addr", bus.avm_address_o, 64'h1000);
    check("unaligned_bc", 64'(bus.avm_burstcount_o), 64'd1);
    finish_xfer("unaligned1", 64'h1003, 1, 200);

    // Start while busy is ignored.
    ready_mode = 1; rdv_rand = 1'b1; wait_mode = 1;
    start_xfer(64'h3100, 24);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    ptr = 64'h9000; len = LEN_W'(5); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_xfer("ignore_start", 64'h3100, 24, 1000);

    // Asynchronous reset while draining.
    ready_mode = 2; rdv_rand = 1'b0; wait_mode = 0;
    a0 = n_accepts;
    start_xfer(64'h4000, 16);
    c = 0;
    while (!(n_accepts - a0 == 2 && !bus.avm_read_o) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain_reached", 64'(c < 200), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_read", 64'(bus.avm_read_o), 64'd0);
    check("arst_addr", bus.avm_address_o, 64'd0);
    check("arst_bc", 64'(bus.avm_burstcount_o), 64'd0);
    check("arst_valid", 64'(bus.src_valid_o), 64'd0);
    check("arst_data", 64'(bus.src_data_o), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    exp_words.delete(); exp_addr.delete(); exp_bc.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    start_xfer(64'h5000, 12);
    finish_xfer("after_reset", 64'h5000, 12, 500);

    // Address wraps modulo 2^64.
    start_xfer(64'hFFFF_FFFF_FFFF_FFE4, 20);
    finish_xfer("wrap20", 64'hFFFF_FFFF_FFFF_FFE4, 20, 500);

    // Randomized transfers with stalls on both sides.
    wait_mode = 1; ready_mode = 1; rdv_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p = {$urandom, $urandom};
      l = $urandom_range(1, 64);
      start_xfer(p, l);
      finish_xfer("random", p, l, 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
